// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the instruction/data SRAM-bus arbiter.
// The state encoding is mirrored as plain localparams for legacy code.
package sram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/sram_bus_arbiter_starve.sv
// Anti-starvation counter: counts data grants made while instruction waits
// and flags when instruction must be forced to win the next arbitration.
module arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_grant_inst,
    input  logic i_grant_data,
    input  logic i_inst_req,
    output logic o_force_inst
);

    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_cnt;

    // Saturating count of consecutive data wins over a waiting instruction request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_grant_inst) begin
            r_cnt <= '0;
        end else if (i_grant_data) begin
            if (!i_inst_req) begin
                r_cnt <= '0;
            end else if (r_cnt != LIMIT) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_force_inst = (STARVE_LIMIT != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter for one SRAM-like bus: data has priority over instruction
// fetch, one transaction outstanding, handshakes routed only to the owner.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    arb_owner_t r_owner;
    sram_req_t  r_req;
    logic       w_force_inst;
    logic       w_force;
    logic       w_grant_inst;
    logic       w_grant_data;
    logic       w_addr_ok;
    logic       w_data_ok;

    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk          (clk),
        .reset        (reset),
        .i_grant_inst (w_grant_inst),
        .i_grant_data (w_grant_data),
        .i_inst_req   (inst_req),
        .o_force_inst (w_force_inst)
    );

    // Arbitration happens only in IDLE; a forced instruction win needs both requests
    always_comb begin
        w_force      = inst_req & data_req & w_force_inst;
        w_grant_data = (r_state == ST_IDLE) & data_req & ~w_force;
        w_grant_inst = (r_state == ST_IDLE) & inst_req & (w_force | ~data_req);
    end

    // Bridge handshakes qualified by state; a data_ok without an accepted address is dropped
    always_comb begin
        w_addr_ok = ~reset & (r_state == ST_ADDR) & bus_addr_ok;
        w_data_ok = ~reset & bus_data_ok &
                    (((r_state == ST_ADDR) & bus_addr_ok) | (r_state == ST_DATA));
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_inst | w_grant_data) begin
                    w_state_nxt = ST_ADDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (bus_addr_ok & bus_data_ok) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus_addr_ok) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, owner and latched request of the winner
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_INST;
            r_req   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_inst) begin
                r_owner <= OWN_INST;
                r_req   <= {inst_wr, inst_size, inst_addr, inst_wdata};
            end else if (w_grant_data) begin
                r_owner <= OWN_DATA;
                r_req   <= {data_wr, data_size, data_addr, data_wdata};
            end
        end
    end

    assign bus_req      = ~reset & (r_state == ST_ADDR);
    assign bus_wr       = r_req.wr;
    assign bus_size     = r_req.size;
    assign bus_addr     = r_req.addr;
    assign bus_wdata    = r_req.wdata;

    assign inst_addr_ok = w_addr_ok & (r_owner == OWN_INST);
    assign inst_data_ok = w_data_ok & (r_owner == OWN_INST);
    assign data_addr_ok = w_addr_ok & (r_owner == OWN_DATA);
    assign data_data_ok = w_data_ok & (r_owner == OWN_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed scenarios plus random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_sram_bus_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    int checks = 0;
    int failures = 0;

    // Transaction-level reference: is a transfer in flight, was its address taken, who owns it
    bit          m_busy, m_acc, m_own_d;
    logic [66:0] m_req;
    int          m_starve;
    bit          e_bus_req, e_aok, e_dok;

    logic        obs_bus_req, obs_iaok, obs_idok, obs_daok, obs_ddok;
    logic [31:0] obs_bus_addr, obs_irdata;
    logic [66:0] obs_fields;

    sram_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model at the edge
    task automatic step();
        bit win_d;
        @(negedge clk);
        e_bus_req = !reset && m_busy && !m_acc;
        e_aok     = e_bus_req && bus_addr_ok;
        e_dok     = !reset && m_busy && (m_acc || bus_addr_ok) && bus_data_ok;
        obs_bus_req  = bus_req;
        obs_bus_addr = bus_addr;
        obs_fields   = {bus_wr, bus_size, bus_addr, bus_wdata};
        obs_iaok = inst_addr_ok; obs_idok = inst_data_ok;
        obs_daok = data_addr_ok; obs_ddok = data_data_ok;
        obs_irdata = inst_rdata;
        check_eq("bus_req", bus_req, e_bus_req);
        check_eq("bus_fields", obs_fields, m_req);
        check_eq("inst_hs", {inst_addr_ok, inst_data_ok}, {e_aok && !m_own_d, e_dok && !m_own_d});
        check_eq("data_hs", {data_addr_ok, data_data_ok}, {e_aok && m_own_d, e_dok && m_own_d});
        check_eq("rdata", {inst_rdata, data_rdata}, {bus_rdata, bus_rdata});
        @(posedge clk);
        if (reset) begin
            m_busy = 0; m_acc = 0; m_own_d = 0; m_req = '0; m_starve = 0;
        end else if (m_busy) begin
            if (e_dok) m_busy = 0;
            else if (e_aok) m_acc = 1;
        end else if (inst_req || data_req) begin
            win_d   = data_req && !(inst_req && LIMIT != 0 && m_starve >= LIMIT);
            m_own_d = win_d;
            m_req   = win_d ? {data_wr, data_size, data_addr, data_wdata}
                            : {inst_wr, inst_size, inst_addr, inst_wdata};
            if (win_d && inst_req) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            else m_starve = 0;
            m_busy = 1; m_acc = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0; data_wdata = 32'h0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic new_inst();
        inst_wr = 1'($urandom_range(0, 1)); inst_size = 2'($urandom_range(0, 2));
        inst_addr = $urandom; inst_wdata = $urandom;
    endtask

    task automatic new_data();
        data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
        data_addr = $urandom; data_wdata = $urandom;
    endtask

    initial begin
        logic [31:0] q[$];
        idle_inputs();
        reset = 1'b1;
        m_busy = 0; m_acc = 0; m_own_d = 0; m_req = '0; m_starve = 0;
        @(posedge clk);
        #1;

        // Reset with both requests held; data wins on the first free cycle
        inst_req = 1'b1; inst_addr = 32'hBFC00010;
        data_req = 1'b1; data_addr = 32'h80000010;
        step();
        step();
        reset = 1'b0;
        step();
        step();
        check_eq("rst_first_grant", {obs_bus_req, obs_bus_addr}, {1'b1, 32'h80000010});

        // Instruction-only fetch with a slow bridge
        do_reset();
        inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'hBFC00000;
        step();
        step();
        bus_addr_ok = 1'b1;
        step();
        check_eq("inst_aok_t2", {obs_iaok, obs_daok, obs_ddok}, 3'b100);
        inst_req = 1'b0; bus_addr_ok = 1'b0;
        step();
        bus_data_ok = 1'b1; bus_rdata = 32'h3C08BFC0;
        step();
        check_eq("inst_dok_t4", {obs_idok, obs_daok, obs_ddok, obs_irdata}, {3'b100, 32'h3C08BFC0});
        bus_data_ok = 1'b0;

        // Both requesting continuously with a one-cycle bridge: D,D,D,D,I repeating
        do_reset();
        inst_req = 1'b1; inst_addr = 32'hBFC00000;
        data_req = 1'b1; data_addr = 32'h80000000;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        for (int i = 0; i < 22; i++) begin
            step();
            if (obs_bus_req) q.push_back(obs_bus_addr);
        end
        check_eq("order_len", q.size() >= 10, 1'b1);
        for (int i = 0; i < 10 && i < q.size(); i++)
            check_eq($sformatf("order_%0d", i), q[i], (i % 5 == 4) ? 32'hBFC00000 : 32'h80000000);
        idle_inputs();
        step();

        // Data write completing with addr_ok and data_ok together
        do_reset();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
        data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
        step();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        step();
        check_eq("wr_same_cycle", {obs_daok, obs_ddok, obs_iaok, obs_idok}, 4'b1100);
        check_eq("wr_fields", obs_fields, {1'b1, 2'd2, 32'h80001000, 32'hDEADBEEF});
        data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        step();
        check_eq("wr_back_idle", obs_bus_req, 1'b0);

        // Reset while in DATA, then a stray data_ok from the abandoned transfer
        do_reset();
        inst_req = 1'b1; inst_addr = 32'hBFC00100;
        step();
        bus_addr_ok = 1'b1;
        step();
        inst_req = 1'b0; bus_addr_ok = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; bus_data_ok = 1'b1;
        step();
        check_eq("stray_dok_1", {obs_iaok, obs_idok, obs_daok, obs_ddok, obs_bus_req}, 5'b0);
        step();
        check_eq("stray_dok_2", {obs_iaok, obs_idok, obs_daok, obs_ddok, obs_bus_req}, 5'b0);
        bus_data_ok = 1'b0;

        // Requester address changes after acceptance do not reach the bus
        do_reset();
        data_req = 1'b1; data_addr = 32'h80002000;
        step();
        bus_addr_ok = 1'b1;
        step();
        data_req = 1'b0; data_addr = 32'h0; bus_addr_ok = 1'b0;
        step();
        check_eq("hold_addr_data", obs_bus_addr, 32'h80002000);
        bus_data_ok = 1'b1;
        step();
        check_eq("hold_addr_done", {obs_ddok, obs_bus_addr}, {1'b1, 32'h80002000});
        bus_data_ok = 1'b0;

        // Random traffic with requesters that hold until accepted
        do_reset();
        for (int i = 0; i < 800; i++) begin
            bus_addr_ok = ($urandom_range(0, 2) == 0);
            bus_data_ok = ($urandom_range(0, 2) == 0);
            bus_rdata   = $urandom;
            reset       = ($urandom_range(0, 99) == 0);
            step();
            if (inst_req ? (e_aok && !m_own_d) : ($urandom_range(0, 2) == 0)) begin
                inst_req = inst_req ? 1'($urandom_range(0, 1)) : 1'b1;
                new_inst();
            end
            if (data_req ? (e_aok && m_own_d) : ($urandom_range(0, 2) == 0)) begin
                data_req = data_req ? 1'($urandom_range(0, 1)) : 1'b1;
                new_data();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like memory bus (req/addr_ok/data_ok) between the instruction-fetch requester and the data-memory requester.
- Sits between the fetch/memory stages and the bus-to-AXI bridge.
- Grants one transaction at a time, registers the winner's request fields, and routes addr_ok/data_ok/rdata back only to the owner.
- Fixed data-over-instruction priority, with an anti-starvation counter.

Parameters:
- STARVE_LIMIT, 4: number of consecutive data grants while inst_req is pending before instruction is forced to win; 0 disables forcing.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- inst_req  in  1  instruction request, held until inst_addr_ok
- inst_wr  in  1  write enable (normally 0)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  byte address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  instruction address accepted
- inst_data_ok  out  1  instruction transfer complete
- inst_rdata  out  32  read data
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/32/32  data requester, same meanings as the inst_* inputs
- data_addr_ok, data_data_ok, data_rdata  out  1/1/32  data requester, same meanings as the inst_* outputs
- bus_req  out  1  request to bridge
- bus_wr  out  1  registered write enable of owner
- bus_size  out  2  registered size of owner
- bus_addr  out  32  registered address of owner
- bus_wdata  out  32  registered write data of owner
- bus_addr_ok  in  1  bridge accepted address
- bus_data_ok  in  1  bridge completed transfer
- bus_rdata  in  32  bridge read data

Behaviour:
- States: IDLE, ADDR, DATA.
- Owner register: INST or DATA.
- Request register: wr, size, addr, wdata.
- Reset: state=IDLE, owner=INST, request register=0, starve_cnt=0; every output 0.
- IDLE arbitration, in priority order:
  - If inst_req & data_req & STARVE_LIMIT!=0 & starve_cnt==STARVE_LIMIT: grant INST.
  - Else if data_req: grant DATA.
  - Else if inst_req: grant INST.
  - On a grant: latch the winner's fields and go to ADDR next cycle.
  - With no request: stay in IDLE.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on a DATA grant while inst_req=1.
  - Clears on any INST grant.
  - Clears on a DATA grant while inst_req=0.
- bus_req = (state==ADDR). bus_wr, bus_size, bus_addr, bus_wdata always drive the request register.
- ADDR state:
  - If bus_addr_ok: the owner's *_addr_ok = 1 in this same cycle (combinational); next state DATA.
  - If bus_addr_ok & bus_data_ok in the same cycle: the owner's *_data_ok = 1 as well; next state IDLE.
  - Otherwise stay in ADDR.
- DATA state: when bus_data_ok, the owner's *_data_ok = 1 and the next state is IDLE.
- Read data: inst_rdata = data_rdata = bus_rdata, unconditionally. Only the owner's data_ok qualifies it.
- Non-owner: *_addr_ok and *_data_ok are held at 0.
- Latency:
  - A request in IDLE at cycle t gives bus_req=1 at t+1.
  - Minimum t+1 to completion when the bridge returns addr_ok & data_ok together.
  - The next arbitration happens in the IDLE cycle after completion.
- Boundaries:
  - bus_data_ok in IDLE, or bus_data_ok in ADDR without bus_addr_ok: ignored, no master data_ok.
  - A requester dropping req while in ADDR: the transaction still completes, and data_ok is still pulsed to it.
  - Requester input changes after grant have no effect on the bus.
  - Reset in any state returns to IDLE within one cycle; the bus transaction in flight is abandoned and its late bus_data_ok is ignored.
  - At most one outstanding transaction at any time.

Decomposition:
- The shared mips package holds:
  - arb_state_t enum {IDLE, ADDR, DATA}
  - arb_owner_t enum {OWN_INST, OWN_DATA}
  - sram_req_t packed struct {wr, size[1:0], addr[31:0], wdata[31:0]}
- One natural sub-module, arb_starve_ctr: the saturating counter plus the force-instruction compare, parameterised by STARVE_LIMIT.

Test Plan:
- Reset with both reqs held: bus_req=0 and all addr_ok/data_ok=0 during reset. On the first post-reset cycle DATA is granted and bus_req=1 the cycle after.
- inst_req only, addr=0xBFC00000, bridge addr_ok at t+2 and data_ok at t+4 with rdata=0x3C08BFC0:
  - inst_addr_ok pulses at t+2.
  - inst_data_ok pulses at t+4 with inst_rdata=0x3C08BFC0.
  - data_* handshake outputs stay 0.
- Both reqs continuously, STARVE_LIMIT=4, one-cycle bridge: grant order is D,D,D,D,I,D,D,D,D,I; bus_addr shows the latched address of each.
- Bridge returns addr_ok & data_ok in the same cycle for a data write (wr=1, size=2, addr=0x80001000, wdata=0xDEADBEEF): data_addr_ok and data_data_ok pulse together, and the state returns to IDLE the next cycle.
- Reset asserted while in DATA, then a stray bus_data_ok arrives after reset: no master sees data_ok, and bus_req stays 0 until a new request arrives.
- data_addr changed to 0x0 after addr_ok while in DATA: bus_addr keeps the original value until completion.
